// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial feeder and sibling serial FSM blocks.
//   IDLE_BIT_DEFAULT : resting level of a serial line with no word in flight
//   feed_state_t     : IDLE/SHIFT/LAST encoding (2-bit, 0/1/2)
//   cnt_width()      : width of a "bits remaining" counter for a given word width
package serial_word_feeder_pkg;

  localparam logic IDLE_BIT_DEFAULT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LAST  = 2'd2
  } feed_state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left register exposing its MSB.
//   clock, reset : clock, synchronous active-high reset (clears contents)
//   load         : capture load_data (wins over shift)
//   shift        : shift left by one, zero fill
//   load_data    : parallel word
//   msb          : current bit WIDTH-1
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);

  logic [WIDTH-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load)       sh_d = load_data;
    else if (shift) sh_d = {sh_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clock) begin
    if (reset) sh_q <= '0;
    else       sh_q <= sh_d;
  end

  assign msb = sh_q[WIDTH-1];

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on valid/ready and
// drives them MSB-first, one bit per clock, on x. A one-word hold register
// lets a continuous stream go out with no idle bit between words.
//   clock, reset : clock, synchronous active-high reset
//   in_data      : word to serialize
//   in_valid     : in_data valid this cycle
//   in_ready     : a word can be accepted this cycle
//   x            : registered serial bit (IDLE_BIT when no word in flight)
//   first        : registered, high while x carries a word's MSB
//   busy         : registered, high while x carries any data bit
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             first,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  feed_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             first_q, first_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;

  logic             sh_msb;
  logic             shifter_free, hs, load_hold, load_in, to_hold, load_word, shift_en;
  logic [WIDTH-1:0] word;

  // Ready depends only on the hold flag and reset, never on in_valid.
  assign in_ready     = !hold_valid_q && !reset;
  assign hs           = in_valid && in_ready;
  assign shifter_free = (state_q != ST_SHIFT);
  assign load_hold    = shifter_free && hold_valid_q;
  assign load_in      = shifter_free && !hold_valid_q && hs;
  // A word arriving mid-shift parks in hold; the shifter keeps running.
  assign to_hold      = !shifter_free && hs;
  assign load_word    = load_hold || load_in;
  assign word         = load_hold ? hold_q : in_data;
  assign shift_en     = !load_word && (state_q == ST_SHIFT);

  // The MSB goes straight to x on load, so the shifter holds the remaining bits.
  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clock     (clock),
    .reset     (reset),
    .load      (load_word),
    .shift     (shift_en),
    .load_data ({word[WIDTH-2:0], 1'b0}),
    .msb       (sh_msb)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    first_d      = first_q;
    busy_d       = busy_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;

    if (load_word) begin
      state_d = ST_SHIFT;  // WIDTH >= 2, so at least one more bit follows
      x_d     = word[WIDTH-1];
      cnt_d   = CW'(WIDTH - 1);
      busy_d  = 1'b1;
      first_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_SHIFT: begin
          x_d     = sh_msb;
          cnt_d   = cnt_q - CW'(1);
          first_d = 1'b0;
          if (cnt_q == CW'(1)) state_d = ST_LAST;
        end
        ST_LAST: begin
          state_d = ST_IDLE;
          x_d     = IDLE_BIT;
          busy_d  = 1'b0;
          first_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (load_hold) hold_valid_d = 1'b0;
    if (to_hold) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      x_q          <= IDLE_BIT;
      first_q      <= 1'b0;
      busy_q       <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      first_q      <= first_d;
      busy_q       <= busy_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign x     = x_q;
  assign first = first_q;
  assign busy  = busy_q;

endmodule
